// File: rtl/prbs4_checker.sv
`default_nettype none
// ============================================================================
// Module : prbs4_checker
// Self-synchronising x^4+x^3+1 PRBS checker with flywheel lock, error pulse
// and saturating error / checked-bit counters.
// Rev    : 1.0
// ============================================================================
module prbs4_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_CNT   = 8,
    parameter int ERR_THRESH = 4,
    parameter int WINDOW     = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int WERR_W  = $clog2(ERR_THRESH + 1);

    localparam logic [FILL_W-1:0]  C_FILL_DONE = FILL_W'(WIDTH);
    localparam logic [MATCH_W-1:0] C_LOCK_DONE = MATCH_W'(LOCK_CNT);
    localparam logic [WIN_W-1:0]   C_WIN_DONE  = WIN_W'(WINDOW);
    localparam logic [WERR_W-1:0]  C_THRESH    = WERR_W'(ERR_THRESH);

    localparam logic [1:0] C_HUNT   = 2'd0;
    localparam logic [1:0] C_CHECK  = 2'd1;
    localparam logic [1:0] C_LOCKED = 2'd2;

    logic [1:0]         r_state, w_state_next;
    logic [WIDTH-1:0]   r_lfsr, w_lfsr_next;
    logic [FILL_W-1:0]  r_fill, w_fill_next, w_fill_inc;
    logic [MATCH_W-1:0] r_match, w_match_next, w_match_inc;
    logic [WIN_W-1:0]   r_win, w_win_next, w_win_inc;
    logic [WERR_W-1:0]  r_werr, w_werr_next, w_werr_inc;
    logic [CNT_W-1:0]   r_err_cnt, w_err_cnt_next;
    logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_next;
    logic               r_locked, r_err_pulse;
    logic               w_pred, w_mismatch, w_lfsr_zero;
    logic               w_count_bit, w_count_err;

    assign w_pred      = r_lfsr[WIDTH-1] ^ r_lfsr[WIDTH-2];
    assign w_mismatch  = in_bit != w_pred;
    assign w_lfsr_zero = (r_lfsr == '0);
    assign w_fill_inc  = r_fill + FILL_W'(1);
    assign w_match_inc = r_match + MATCH_W'(1);
    assign w_win_inc   = r_win + WIN_W'(1);
    assign w_werr_inc  = r_werr + WERR_W'(1);
    assign w_count_bit = in_valid && (r_state == C_LOCKED);
    assign w_count_err = w_count_bit && w_mismatch;

    always_ff @(posedge clk) begin : p_state_reg
        if (!reset) begin
            r_state <= C_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin : p_next_state
        w_state_next = r_state;
        case (r_state)
            C_HUNT: begin
                if (in_valid && (w_fill_inc == C_FILL_DONE)) w_state_next = C_CHECK;
            end
            C_CHECK: begin
                if (in_valid) begin
                    if (w_lfsr_zero) w_state_next = C_HUNT;
                    else if (!w_mismatch && (w_match_inc == C_LOCK_DONE)) w_state_next = C_LOCKED;
                end
            end
            C_LOCKED: begin
                if (in_valid && w_mismatch && (w_werr_inc == C_THRESH)) w_state_next = C_HUNT;
            end
            default: w_state_next = C_HUNT;
        endcase
    end

    always_comb begin : p_datapath_next
        w_lfsr_next  = r_lfsr;
        w_fill_next  = r_fill;
        w_match_next = r_match;
        w_win_next   = r_win;
        w_werr_next  = r_werr;
        if (in_valid) begin
            case (r_state)
                C_HUNT: begin
                    w_lfsr_next  = {r_lfsr[WIDTH-2:0], in_bit};
                    w_fill_next  = w_fill_inc;
                    w_match_next = '0;
                end
                C_CHECK: begin
                    w_lfsr_next = {r_lfsr[WIDTH-2:0], in_bit};
                    if (w_lfsr_zero) begin
                        // all-zero is the LFSR lock-up state: refill rather than lock onto it
                        w_fill_next = '0;
                    end else if (!w_mismatch) begin
                        w_match_next = w_match_inc;
                        if (w_match_inc == C_LOCK_DONE) begin
                            w_win_next  = '0;
                            w_werr_next = '0;
                        end
                    end else begin
                        w_match_next = '0;
                    end
                end
                C_LOCKED: begin
                    // flywheel: shift the prediction so one bad bit costs exactly one error
                    w_lfsr_next = {r_lfsr[WIDTH-2:0], w_pred};
                    if (w_mismatch && (w_werr_inc == C_THRESH)) begin
                        w_lfsr_next = '0;
                        w_fill_next = '0;
                        w_win_next  = '0;
                        w_werr_next = '0;
                    end else if (w_win_inc == C_WIN_DONE) begin
                        w_win_next  = '0;
                        w_werr_next = '0;
                    end else begin
                        w_win_next = w_win_inc;
                        if (w_mismatch) w_werr_next = w_werr_inc;
                    end
                end
                default: ;
            endcase
        end

        if (clear) begin
            w_err_cnt_next = CNT_W'(w_count_err);
            w_bit_cnt_next = CNT_W'(w_count_bit);
        end else begin
            w_err_cnt_next = r_err_cnt;
            w_bit_cnt_next = r_bit_cnt;
            if (w_count_err && (r_err_cnt != '1)) w_err_cnt_next = r_err_cnt + CNT_W'(1);
            if (w_count_bit && (r_bit_cnt != '1)) w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin : p_datapath_reg
        if (!reset) begin
            r_lfsr      <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_win       <= '0;
            r_werr      <= '0;
            r_err_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_lfsr      <= w_lfsr_next;
            r_fill      <= w_fill_next;
            r_match     <= w_match_next;
            r_win       <= w_win_next;
            r_werr      <= w_werr_next;
            r_err_cnt   <= w_err_cnt_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_locked    <= (w_state_next == C_LOCKED);
            r_err_pulse <= w_count_err;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign bit_cnt   = r_bit_cnt;

endmodule
`default_nettype wire

// File: doc/prbs4_checker.md
Name: prbs4_checker

Overview:
- Receive-side counterpart of the 4-bit Fibonacci LFSR pattern generator: consumes the serial PRBS stream (polynomial x^4+x^3+1, period 15) and self-synchronises to it.
- Flags every bit error and counts errors and checked bits.
- Declares and drops lock autonomously.
- Sits at the far end of a link or loopback path, fed one bit per valid cycle.

Parameters:
- WIDTH, 4, LFSR length; fixed at 4 for this polynomial.
- LOCK_CNT, 8, consecutive correct predictions in CHECK needed to enter LOCKED.
- ERR_THRESH, 4, errors within one window that force loss of lock.
- WINDOW, 32, LOCKED-state bit window length for ERR_THRESH evaluation.
- CNT_W, 16, width of err_cnt and bit_cnt.

Ports:
- clk, in, 1, single clock; all logic on rising edge.
- reset, in, 1, synchronous active-low reset.
- clear, in, 1, synchronous zeroing of err_cnt and bit_cnt only; state and lock unaffected.
- in_valid, in, 1, in_bit is sampled this cycle.
- in_bit, in, 1, received serial PRBS bit.
- locked, out, 1, high while FSM is in LOCKED.
- err_pulse, out, 1, one-cycle pulse per mismatched bit while LOCKED.
- err_cnt, out, CNT_W, saturating count of LOCKED-state mismatches.
- bit_cnt, out, CNT_W, saturating count of bits checked while LOCKED.

Behaviour:
- Generator reference model:
  - State s[3:0]; fb = s[3]^s[2]; next s = {s[2:0], fb}; serial output = fb.
  - Seed 4'b1010 yields 1,1,1,1,0,0,0,1,0,0,1,1,0,1,0 (then repeats).
- Checker register r[3:0]:
  - Predicted bit p = r[3]^r[2].
  - "Shift x" means r <= {r[2:0], x}.
- Cycles with in_valid=0: no state change, err_pulse=0, counters hold.
- Reset (reset=0 at edge), regardless of state:
  - FSM=HUNT, r=0, fill count=0, match count=0, window count=0, window error count=0.
  - locked=0, err_pulse=0, err_cnt=0, bit_cnt=0.
  - A reset mid-lock drops lock on the same edge.
- HUNT:
  - Each valid bit: shift in_bit, fill count+1.
  - After the WIDTH-th bit, go to CHECK with match count=0.
- CHECK:
  - Each valid bit: shift in_bit (received, not predicted).
  - If r==0 before the shift: go to HUNT, fill count=0. All-zero is the LFSR lock-up state and must never lock.
  - Else if in_bit==p: match count+1; on reaching LOCK_CNT go to LOCKED and clear window count and window error count.
  - Else: match count=0, stay in CHECK.
  - No err_pulse and no counting in HUNT or CHECK.
- LOCKED (flywheel):
  - Each valid bit: shift p (prediction, not in_bit), so a single corrupted bit produces exactly one error.
  - bit_cnt+1, saturating at all-ones.
  - If in_bit!=p: err_pulse=1 next cycle, err_cnt+1 (saturating), window error count+1.
  - Window count+1 per valid bit.
  - When window error count reaches ERR_THRESH: go to HUNT, fill count=0, r=0.
  - When window count reaches WINDOW without hitting threshold: both window counters reset to 0.
  - The bit that hits the threshold still pulses err_pulse and is counted.
- Timing: all outputs registered. locked rises on the edge that consumes the LOCK_CNT-th CHECK match, so it is visible the cycle after that bit's in_valid. Minimum lock latency is WIDTH+LOCK_CNT valid bits.
- clear coincident with a counted error: counter loads 1, not 0. clear has priority over the hold; reset has priority over clear.
- err_pulse is 0 in every cycle not immediately following a LOCKED mismatch.

Test Plan:
- Reset, then stream the seed-1010 sequence continuously with in_valid=1 → locked=1 in the cycle after bit 12, err_pulse never asserted, err_cnt=0. bit_cnt=30 after 30 further bits.
- Locked stream, invert one bit (bit 20) → exactly one err_pulse, one cycle after that bit; err_cnt=1; locked stays 1; subsequent bits show no errors.
- Locked stream, invert 4 bits within 32 → err_cnt=4, locked falls with the 4th error. With a clean stream continuing, relock occurs after 12 further valid bits.
- All-zero input for 40 bits after reset → locked never asserts, FSM cycles HUNT/CHECK, err_cnt=0.
- Toggle in_valid 1/0 every cycle during the clean sequence → lock after 12 valid bits (24 cycles), identical counts to the continuous case.
- While locked with err_cnt=3, assert reset=0 for one cycle → next cycle locked=0, err_cnt=0, bit_cnt=0. Assert clear with an error on the same bit → err_cnt=1.
